// File: rtl/ls_pkg.sv
// Shared definitions for the ls_shift_out serial transmitter.
// Contents:
//   StateW     - width of the FSM state encoding
//   ls_state_e - FSM states (idle, shifting, parity bit, completion pulse)
package ls_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StPar   = 2'd2,
    StDone  = 2'd3
  } ls_state_e;

endpackage

// File: rtl/ls_bitcnt.sv
// Down counter with synchronous load, count enable and terminal-zero flag.
// The counter stops at zero instead of wrapping.
// Ports:
//   clk_i      - rising-edge clock
//   rst_ni     - asynchronous active-low reset (counter cleared to 0)
//   load_i     - load load_val_i (has priority over en_i)
//   load_val_i - value to load
//   en_i       - decrement by one when nonzero
//   zero_o     - counter currently holds 0
module ls_bitcnt #(
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ls_shift_out.sv
// Parallel-in, serial-out transmitter. Captures an N-bit word when idle and
// sends it MSB first, one bit per cycle, with a frame strobe and a one-cycle
// completion pulse. c_i low freezes the stream.
// Optional feature: define LS_SHIFT_PARITY_EN to append an even-parity bit
// after the data bits.
// Ports:
//   clk_i    - rising-edge clock
//   clr_ni   - asynchronous active-low reset; forces all outputs low
//   in_i     - parallel word to transmit
//   load_i   - capture in_i (only honoured while ready_o is high)
//   c_i      - advance enable (0 stalls the stream)
//   ready_o  - idle and able to accept a load
//   sout_o   - serial data bit
//   sframe_o - sout_o carries a valid bit
//   done_o   - one-cycle pulse after the last bit
module ls_shift_out
  import ls_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk_i,
  input  logic         clr_ni,
  input  logic [N-1:0] in_i,
  input  logic         load_i,
  input  logic         c_i,
  output logic         ready_o,
  output logic         sout_o,
  output logic         sframe_o,
  output logic         done_o
);

  localparam int unsigned CntW = $clog2(N);
  localparam logic [CntW-1:0] CntInit = CntW'(N - 1);

  ls_state_e    state_q, state_d;
  logic [N-1:0] shreg_q, shreg_d;
  logic         cnt_load, cnt_en, cnt_zero;

`ifdef LS_SHIFT_PARITY_EN
  logic         par_q, par_d;
`endif

  ls_bitcnt #(
    .Width (CntW)
  ) u_bitcnt (
    .clk_i      (clk_i),
    .rst_ni     (clr_ni),
    .load_i     (cnt_load),
    .load_val_i (CntInit),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero)
  );

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
`ifdef LS_SHIFT_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      StIdle: begin
        if (load_i) begin
          shreg_d  = in_i;
          cnt_load = 1'b1;
          state_d  = StShift;
`ifdef LS_SHIFT_PARITY_EN
          par_d    = ^in_i;
`endif
        end
      end
      StShift: begin
        if (c_i) begin
          shreg_d = shreg_q << 1;
          cnt_en  = 1'b1;
          // Counter reaching zero means the bit on the line now is bit 0.
          if (cnt_zero) begin
`ifdef LS_SHIFT_PARITY_EN
            state_d = StPar;
`else
            state_d = StDone;
`endif
          end
        end
      end
`ifdef LS_SHIFT_PARITY_EN
      StPar: begin
        if (c_i) begin
          state_d = StDone;
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode registered state only; ready_o also gated by reset.
  always_comb begin
    ready_o  = 1'b0;
    sout_o   = 1'b0;
    sframe_o = 1'b0;
    done_o   = 1'b0;
    case (state_q)
      StIdle:  ready_o = clr_ni;
      StShift: begin
        sframe_o = 1'b1;
        sout_o   = shreg_q[N-1];
      end
`ifdef LS_SHIFT_PARITY_EN
      StPar: begin
        sframe_o = 1'b1;
        sout_o   = par_q;
      end
`endif
      StDone:  done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      state_q <= StIdle;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

`ifdef LS_SHIFT_PARITY_EN
  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

endmodule
